// File: rtl/mem_march_initiator.sv
// March-test BIST master for a single-port memory: write background, read/write-inverse, descending read.
// Optional build macro BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module mem_march_initiator #(
  parameter int LOCATIONS = 16,
  parameter int LOC_SIZE  = 8,
  localparam int ADDR_W   = $clog2(LOCATIONS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [LOC_SIZE-1:0] pattern_i,
  output logic                mem_reset_o,
  output logic                mem_op_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LOC_SIZE-1:0] mem_data_in_o,
  input  logic [LOC_SIZE-1:0] mem_data_out_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                fail_o,
  output logic [7:0]          fail_count_o,
  output logic [ADDR_W-1:0]   fail_addr_o,
  output logic [LOC_SIZE-1:0] fail_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOCATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_WBG, S_RW, S_RD, S_CHK, S_DONE
  } state_t;

  state_t                state_q;
  logic [LOC_SIZE-1:0]   pat_q;
  logic                  mreset_q;
  logic                  op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LOC_SIZE-1:0]   wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  fail_q;
  logic [7:0]            fcnt_q;
  logic [ADDR_W-1:0]     faddr_q;
  logic [LOC_SIZE-1:0]   fdata_q;

  // Read bookkeeping: *_rd_* describes the read on the bus this cycle,
  // *_cmp_* the read whose data is on mem_data_out_i this cycle.
  logic                  rd_vld_q;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic [LOC_SIZE-1:0]   rd_exp_q;
  logic                  cmp_vld_q;
  logic [ADDR_W-1:0]     cmp_addr_q;
  logic [LOC_SIZE-1:0]   cmp_exp_q;

  logic                  mismatch_d;
  logic [7:0]            fcnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    mismatch_d = cmp_vld_q && (mem_data_out_i != cmp_exp_q);
    fcnt_d     = sat_inc(fcnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      mreset_q  <= 1'b1;
      op_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      fcnt_q    <= 8'd0;
      faddr_q   <= '0;
      fdata_q   <= '0;
      rd_vld_q  <= 1'b0;
      cmp_vld_q <= 1'b0;
    end else begin
      mreset_q   <= 1'b0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      cmp_vld_q  <= rd_vld_q;
      cmp_addr_q <= rd_addr_q;
      cmp_exp_q  <= rd_exp_q;

      if (mismatch_d) begin
        fail_q <= 1'b1;
        fcnt_q <= fcnt_d;
        if (!fail_q) begin
          faddr_q <= cmp_addr_q;
          fdata_q <= mem_data_out_i;
        end
      end

      case (state_q)
        S_IDLE: begin
          op_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          if (start_i) begin
            state_q  <= S_CLR;
            pat_q    <= pattern_i;
            mreset_q <= 1'b1;
            busy_q   <= 1'b1;
            fail_q   <= 1'b0;
            fcnt_q   <= 8'd0;
            faddr_q  <= '0;
            fdata_q  <= '0;
          end
        end
        S_CLR: begin
          state_q <= S_WBG;
          op_q    <= 1'b1;
          addr_q  <= '0;
          wdata_q <= pat_q;
        end
        S_WBG: begin
          if (addr_q == LAST_ADDR) begin
            state_q   <= S_RW;
            op_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_vld_q  <= 1'b1;
            rd_addr_q <= '0;
            rd_exp_q  <= pat_q;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            wdata_q <= pat_q;
          end
        end
        S_RW: begin
          if (!op_q) begin
            op_q    <= 1'b1;
            wdata_q <= ~pat_q;
          end else if (addr_q == LAST_ADDR) begin
            state_q   <= S_RD;
            op_q      <= 1'b0;
            wdata_q   <= '0;
            rd_vld_q  <= 1'b1;
            rd_addr_q <= LAST_ADDR;
            rd_exp_q  <= ~pat_q;
          end else begin
            op_q      <= 1'b0;
            addr_q    <= addr_q + ADDR_W'(1);
            wdata_q   <= '0;
            rd_vld_q  <= 1'b1;
            rd_addr_q <= addr_q + ADDR_W'(1);
            rd_exp_q  <= pat_q;
          end
        end
        S_RD: begin
          if (addr_q == '0) begin
            state_q <= S_CHK;
          end else begin
            addr_q    <= addr_q - ADDR_W'(1);
            rd_vld_q  <= 1'b1;
            rd_addr_q <= addr_q - ADDR_W'(1);
            rd_exp_q  <= ~pat_q;
          end
        end
        S_CHK: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          op_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

`ifdef BIST_STOP_ON_FAIL_EN
      // First mismatch cuts the run short; nothing further is issued.
      if (mismatch_d) begin
        state_q   <= S_DONE;
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
        op_q      <= 1'b0;
        addr_q    <= '0;
        wdata_q   <= '0;
        rd_vld_q  <= 1'b0;
        cmp_vld_q <= 1'b0;
      end
`endif
    end
  end

  assign mem_reset_o   = mreset_q;
  assign mem_op_o      = op_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_in_o = wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign fail_count_o  = fcnt_q;
  assign fail_addr_o   = faddr_q;
  assign fail_data_o   = fdata_q;

endmodule

// File: tb/tb_mem_march_initiator.sv
// Directed bench for mem_march_initiator with a behavioural 16x8 memory and an optional stuck-at fault.
module tb_mem_march_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic       mem_reset;
  logic       mem_op;
  logic [3:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       busy;
  logic       done;
  logic       fail;
  logic [7:0] fail_count;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [16];
  bit         stuck = 1'b0;

  int done_cyc, busy_low, wr_n, rd_n, late_wr, fail_cyc, done_seen;

  mem_march_initiator #(.LOCATIONS(16), .LOC_SIZE(8)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .pattern_i      (pattern),
    .mem_reset_o    (mem_reset),
    .mem_op_o       (mem_op),
    .mem_addr_o     (mem_addr),
    .mem_data_in_o  (mem_data_in),
    .mem_data_out_i (mem_data_out),
    .busy_o         (busy),
    .done_o         (done),
    .fail_o         (fail),
    .fail_count_o   (fail_count),
    .fail_addr_o    (fail_addr),
    .fail_data_o    (fail_data)
  );

  always #5 clk = ~clk;

  // Memory: registered read data, bit0 of location 5 optionally stuck at 0.
  always @(posedge clk) begin
    if (mem_reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem_data_out <= 8'h00;
    end else begin
      if (mem_op)
        mem[mem_addr] <= (stuck && mem_addr == 4'd5) ? (mem_data_in & 8'hFE) : mem_data_in;
      mem_data_out <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run with P=A5 and follow it until done (bounded), gathering statistics.
  task automatic run(input bit hold);
    int c;
    start   = 1'b1;
    pattern = 8'hA5;
    tick();
    start = 1'b0;
    chk("c1_mem_reset", mem_reset, 1);
    chk("c1_busy", busy, 1);
    chk("c1_fail", fail, 0);
    chk("c1_fail_count", fail_count, 0);
    chk("c1_fail_addr", fail_addr, 0);
    chk("c1_fail_data", fail_data, 0);
    done_cyc = 0; busy_low = 0; wr_n = 0; rd_n = 0; late_wr = 0; fail_cyc = 0;
    c = 1;
    while (c <= 120) begin
      if (!busy) busy_low++;
      if (c >= 2 && c <= 65) begin
        if (mem_op) wr_n++;
        else rd_n++;
      end
      if (mem_op && c > 29) late_wr++;
      if (fail && fail_cyc == 0) fail_cyc = c;
      if (done) begin
        done_cyc = c;
        break;
      end
      start = hold && c >= 10 && c < 20;
      tick();
      c++;
    end
    start = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = 8'h00;
    repeat (3) tick();
    chk("rst_mem_reset", mem_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op", mem_op, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fail_count", fail_count, 0);
    reset = 1'b0;
    tick();
    chk("rel_mem_reset", mem_reset, 0);
    chk("rel_busy", busy, 0);
    tick();

    // Fault-free run
    run(1'b0);
    chk("t1_done_cyc", done_cyc, 67);
    chk("t1_busy_low", busy_low, 1);
    chk("t1_fail", fail, 0);
    chk("t1_fail_count", fail_count, 0);
    chk("t1_writes", wr_n, 32);
    chk("t1_reads", rd_n, 32);
    chk("t1_done_op", mem_op, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Stuck-at fault on bit0 of location 5
    stuck = 1'b1;
    tick();
    run(1'b0);
`ifdef BIST_STOP_ON_FAIL_EN
    chk("t3_done_cyc", done_cyc, 30);
    chk("t3_writes", wr_n, 22);
    chk("t3_late_writes", late_wr, 0);
`else
    chk("t2_done_cyc", done_cyc, 67);
    chk("t2_writes", wr_n, 32);
`endif
    chk("t2_fail_cyc", fail_cyc, 30);
    chk("t2_fail", fail, 1);
    chk("t2_fail_count", fail_count, 1);
    chk("t2_fail_addr", fail_addr, 5);
    chk("t2_fail_data", fail_data, 8'hA4);

    // Fault repaired: second start clears flags and passes
    stuck = 1'b0;
    tick();
    run(1'b0);
    chk("t6_done_cyc", done_cyc, 67);
    chk("t6_fail", fail, 0);
    chk("t6_fail_count", fail_count, 0);
    chk("t6_fail_addr", fail_addr, 0);

    // start held for 10 cycles mid-run
    tick();
    run(1'b1);
    chk("t4_done_cyc", done_cyc, 67);
    chk("t4_busy_low", busy_low, 1);
    tick();
    chk("t4_no_rerun_busy", busy, 0);
    tick();
    chk("t4_no_rerun_mem_reset", mem_reset, 0);
    chk("t4_no_rerun_busy2", busy, 0);

    // Reset asserted in cycle 20
    start   = 1'b1;
    pattern = 8'hA5;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("t5_busy_c20", busy, 1);
    reset = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_mem_reset", mem_reset, 1);
    chk("t5_op", mem_op, 0);
    chk("t5_done", done, 0);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done) done_seen++;
    end
    chk("t5_no_done", done_seen, 0);
    run(1'b0);
    chk("t5_rerun_done_cyc", done_cyc, 67);
    chk("t5_rerun_fail", fail, 0);
    chk("t5_rerun_reads", rd_n, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
